// File: rtl/ram_req_ctrl_if.sv
// Command/response channel bundle between a requester and ram_req_ctrl.
// The requester uses the master modport and the controller uses the slave modport.
interface ram_req_ctrl_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_req_ctrl.sv
// Front-end for a single-port synchronous RAM: zero-fills the RAM after reset,
// then serves one read or write command at a time over valid/ready channels.
module ram_req_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 2,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   ram_req_ctrl_if.slave     bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              init_done
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int WAIT_W = $clog2(RD_LAT + 1);
   localparam logic [ADDR_W:0]   INIT_END  = (ADDR_W + 1)'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      ISSUE,
      RD_WAIT,
      RESP
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   init_cnt, init_cnt_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

   logic              req_ready_q, req_ready_nxt;
   logic              rsp_valid_q, rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
   logic              ram_en_nxt, ram_we_nxt;
   logic [ADDR_W-1:0] ram_addr_nxt;
   logic [DATA_W-1:0] ram_wdata_nxt;
   logic              init_done_nxt;

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   // Every output is a flop; this block only loads the values chosen below.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= INIT;
         init_cnt    <= '0;
         wait_cnt    <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         init_done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         init_cnt    <= init_cnt_nxt;
         wait_cnt    <= wait_cnt_nxt;
         req_ready_q <= req_ready_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_rdata_q <= rsp_rdata_nxt;
         ram_en      <= ram_en_nxt;
         ram_we      <= ram_we_nxt;
         ram_addr    <= ram_addr_nxt;
         ram_wdata   <= ram_wdata_nxt;
         init_done   <= init_done_nxt;
      end
   end

   // Next state and next output values; anything not assigned holds its value.
   always_comb begin
      state_nxt     = state;
      init_cnt_nxt  = init_cnt;
      wait_cnt_nxt  = wait_cnt;
      req_ready_nxt = req_ready_q;
      rsp_valid_nxt = rsp_valid_q;
      rsp_rdata_nxt = rsp_rdata_q;
      ram_en_nxt    = ram_en;
      ram_we_nxt    = ram_we;
      ram_addr_nxt  = ram_addr;
      ram_wdata_nxt = ram_wdata;
      init_done_nxt = init_done;

      unique case (state)
         INIT: begin
            // init_cnt reaching DEPTH means the last zero write is on the pins now
            if (init_cnt == INIT_END) begin
               state_nxt     = IDLE;
               ram_en_nxt    = 1'b0;
               ram_we_nxt    = 1'b0;
               req_ready_nxt = 1'b1;
               init_done_nxt = 1'b1;
            end else begin
               ram_en_nxt    = 1'b1;
               ram_we_nxt    = 1'b1;
               ram_addr_nxt  = init_cnt[ADDR_W-1:0];
               ram_wdata_nxt = '0;
               init_cnt_nxt  = init_cnt + (ADDR_W + 1)'(1);
            end
         end

         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               state_nxt     = ISSUE;
               req_ready_nxt = 1'b0;
               ram_en_nxt    = 1'b1;
               ram_we_nxt    = bus.req_write;
               ram_addr_nxt  = bus.req_addr;
               ram_wdata_nxt = bus.req_wdata;
            end
         end

         ISSUE: begin
            // ram_we still carries the accepted command's write flag here
            ram_en_nxt = 1'b0;
            if (ram_we) begin
               state_nxt     = IDLE;
               req_ready_nxt = 1'b1;
            end else begin
               state_nxt    = RD_WAIT;
               wait_cnt_nxt = '0;
            end
         end

         RD_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nxt     = RESP;
               rsp_rdata_nxt = ram_rdata;
               rsp_valid_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               req_ready_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3,
// each wired to its own behavioural RAM; sel chooses which instance the tasks drive.
module tb_ram_req_ctrl;
   localparam int AW = 2;
   localparam int DW = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   ram_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

   logic          en1, we1, done1, en3, we3, done3;
   logic [AW-1:0] addr1, addr3;
   logic [DW-1:0] wdata1, rdata1, wdata3, rdata3;

   ram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1.slave),
      .ram_en(en1), .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1),
      .ram_rdata(rdata1), .init_done(done1)
   );

   ram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
      .clock(clock), .reset(reset), .bus(bus3.slave),
      .ram_en(en3), .ram_we(we3), .ram_addr(addr3), .ram_wdata(wdata3),
      .ram_rdata(rdata3), .init_done(done3)
   );

   // RAMs start full of ones so the zeroing sweep is observable
   logic [DW-1:0] mem1 [4] = '{default: '1};
   logic [DW-1:0] mem3 [4] = '{default: '1};
   logic [DW-1:0] pipe1 [1] = '{default: '0};
   logic [DW-1:0] pipe3 [3] = '{default: '0};

   always @(posedge clock) begin
      if (en1 && we1) mem1[addr1] <= wdata1;
      if (en1 && !we1) pipe1[0] <= mem1[addr1];
   end
   assign rdata1 = pipe1[0];

   always @(posedge clock) begin
      if (en3 && we3) mem3[addr3] <= wdata3;
      if (en3 && !we3) pipe3[0] <= mem3[addr3];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign rdata3 = pipe3[2];

   logic          sel = 1'b0;
   logic          req_valid_v = 1'b0, req_write_v = 1'b0, rsp_ready_v = 1'b1;
   logic [AW-1:0] req_addr_v = '0;
   logic [DW-1:0] req_wdata_v = '0;

   assign bus1.req_valid = req_valid_v & ~sel;
   assign bus3.req_valid = req_valid_v & sel;
   assign bus1.req_write = req_write_v;
   assign bus3.req_write = req_write_v;
   assign bus1.req_addr  = req_addr_v;
   assign bus3.req_addr  = req_addr_v;
   assign bus1.req_wdata = req_wdata_v;
   assign bus3.req_wdata = req_wdata_v;
   assign bus1.rsp_ready = rsp_ready_v;
   assign bus3.rsp_ready = rsp_ready_v;

   logic          req_ready_s, rsp_valid_s, en_s, we_s, done_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdata_s, rsp_rdata_s;
   assign req_ready_s = sel ? bus3.req_ready : bus1.req_ready;
   assign rsp_valid_s = sel ? bus3.rsp_valid : bus1.rsp_valid;
   assign rsp_rdata_s = sel ? bus3.rsp_rdata : bus1.rsp_rdata;
   assign en_s        = sel ? en3 : en1;
   assign we_s        = sel ? we3 : we1;
   assign addr_s      = sel ? addr3 : addr1;
   assign wdata_s     = sel ? wdata3 : wdata1;
   assign done_s      = sel ? done3 : done1;

   logic [DW-1:0] model [2][4];
   logic [DW-1:0] exp_q [$];
   int vectors = 0;
   int miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses reset for one edge starting at the next negedge, then follows the sweep.
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      req_valid_v = 1'b0;
      rsp_ready_v = 1'b1;
      @(negedge clock);
      checkOutput("rst_req_ready", req_ready_s, 0);
      checkOutput("rst_rsp_valid", rsp_valid_s, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata_s, 0);
      checkOutput("rst_ram_en", en_s, 0);
      checkOutput("rst_ram_addr", addr_s, 0);
      checkOutput("rst_init_done", done_s, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("sweep_en", en_s, 1);
         checkOutput("sweep_we", we_s, 1);
         checkOutput("sweep_addr", addr_s, i);
         checkOutput("sweep_wdata", wdata_s, 0);
         checkOutput("sweep_req_ready", req_ready_s, 0);
         checkOutput("sweep_init_done", done_s, 0);
      end
      @(negedge clock);
      checkOutput("post_sweep_init_done", done_s, 1);
      checkOutput("post_sweep_req_ready", req_ready_s, 1);
      checkOutput("post_sweep_en", en_s, 0);
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 4; a++) model[d][a] = '0;
      exp_q.delete();
   endtask

   // Presents one command, waits for acceptance and checks the ISSUE cycle.
   // Returns in the ISSUE cycle; waits = negedges spent before req_ready was seen.
   task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, output int waits);
      req_valid_v = 1'b1;
      req_write_v = wr;
      req_addr_v  = addr;
      req_wdata_v = data;
      waits = 0;
      while (!req_ready_s && waits < 20) begin
         @(negedge clock);
         waits++;
      end
      if (!req_ready_s) begin
         checkOutput("accept_timeout", 0, 1);
         req_valid_v = 1'b0;
         return;
      end
      checkOutput("idle_en", en_s, 0);
      if (wr) model[sel][addr] = data;
      else exp_q.push_back(model[sel][addr]);
      @(negedge clock);
      req_valid_v = 1'b0;
      req_write_v = ~wr;
      req_addr_v  = ~addr;
      req_wdata_v = ~data;
      checkOutput("issue_en", en_s, 1);
      checkOutput("issue_we", we_s, wr);
      checkOutput("issue_addr", addr_s, addr);
      checkOutput("issue_req_ready", req_ready_s, 0);
      if (wr) checkOutput("issue_wdata", wdata_s, data);
   endtask

   // Entered in the ISSUE cycle of a read; stalls the response hold cycles.
   task automatic wait_rsp(input int hold);
      int lat;
      logic [DW-1:0] exp;
      lat = 1;
      rsp_ready_v = (hold == 0);
      while (!rsp_valid_s && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      checkOutput("rsp_latency", lat, sel ? 5 : 3);
      if (!rsp_valid_s) begin
         rsp_ready_v = 1'b1;
         return;
      end
      if (exp_q.size() == 0) begin
         checkOutput("scoreboard_empty", 1, 0);
         rsp_ready_v = 1'b1;
         return;
      end
      exp = exp_q.pop_front();
      checkOutput("rsp_rdata", rsp_rdata_s, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         checkOutput("hold_valid", rsp_valid_s, 1);
         checkOutput("hold_rdata", rsp_rdata_s, exp);
         checkOutput("hold_req_ready", req_ready_s, 0);
      end
      rsp_ready_v = 1'b1;
      @(negedge clock);
      checkOutput("release_valid", rsp_valid_s, 0);
      checkOutput("release_req_ready", req_ready_s, 1);
   endtask

   logic [DW-1:0] b2b_data [4] = '{2'b01, 2'b10, 2'b11, 2'b01};

   initial begin
      int w;
      sel = 1'b0;
      do_reset();
      checkOutput("dut3_init_done", done3, 1);

      applyStimulus(1'b0, 2'd3, '0, w);
      wait_rsp(0);

      applyStimulus(1'b1, 2'd2, 2'b10, w);
      applyStimulus(1'b0, 2'd2, '0, w);
      checkOutput("write_to_read_gap", w, 1);
      wait_rsp(0);

      applyStimulus(1'b0, 2'd2, '0, w);
      wait_rsp(6);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, AW'(i), b2b_data[i], w);
         if (i > 0) checkOutput("b2b_write_gap", w, 1);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, AW'(i), '0, w);
         wait_rsp(0);
      end

      sel = 1'b1;
      applyStimulus(1'b1, 2'd1, 2'b01, w);
      applyStimulus(1'b0, 2'd1, '0, w);
      wait_rsp(0);

      sel = 1'b0;
      applyStimulus(1'b0, 2'd1, '0, w);
      do_reset();
      applyStimulus(1'b0, 2'd1, '0, w);
      wait_rsp(0);
      applyStimulus(1'b0, 2'd2, '0, w);
      wait_rsp(0);

      repeat (2) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
- Request/response front-end that sits directly upstream of the single-port synchronous RAM model and owns all of its control pins.
- Accepts read/write commands over a valid/ready handshake, sequences the RAM enable, write-enable, address and data, and returns read data over a valid/ready response channel.
- After every reset, sweeps the whole RAM writing zeros so downstream logic never sees uninitialised contents.

Parameters:
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W.
- DATA_W, 2, data width.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..4.

Ports:
- clock  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  controller can accept a command.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  command address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_W  read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable; qualified by ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid RD_LAT cycles after a read strobe.
- init_done  out  1  high once the zeroing sweep has completed.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- All outputs are registered.
- Reset values:
  - State INIT, init counter 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - init_done=0.
- States and transitions:
  - INIT:
    - First cycle after reset deasserts through cycle DEPTH: ram_en=1, ram_we=1, ram_wdata=0, ram_addr=counter, where counter runs 0..DEPTH-1.
    - After the write to DEPTH-1, go to IDLE and set init_done=1; init_done stays 1 until the next reset.
    - req_ready=0 throughout INIT.
  - IDLE:
    - req_ready=1, ram_en=0.
    - Command accepted on any cycle A with req_valid and req_ready both high; latch write flag, address and data; go to ISSUE.
    - req_ready drops to 0 in cycle A+1.
  - ISSUE (cycle A+1):
    - ram_en=1, ram_addr=latched address.
    - Write: ram_we=1, ram_wdata=latched data; next state IDLE, so req_ready=1 again in A+2.
    - Read: ram_we=0; next state RD_WAIT.
  - RD_WAIT:
    - Lasts exactly RD_LAT cycles, A+2..A+1+RD_LAT; wait counter width is ceil(log2(RD_LAT+1)).
    - ram_en=0.
    - Sample ram_rdata into rsp_rdata at the end of the last wait cycle; go to RESP.
  - RESP:
    - rsp_valid=1 from cycle A+2+RD_LAT; rsp_rdata held stable.
    - Remains in RESP until rsp_ready=1, then rsp_valid=0 next cycle and state returns to IDLE.
    - rsp_ready has no effect when rsp_valid=0.
- Throughput:
  - Write: one per 2 cycles.
  - Read: one per 3+RD_LAT cycles with rsp_ready held high.
  - Only one command is outstanding at a time.
- Stability rule: req_write, req_addr and req_wdata are sampled only at acceptance; changes at any other time are ignored.
- ram_wdata and ram_we may hold stale values whenever ram_en=0; checkers qualify both with ram_en.
- Reset mid-operation:
  - Any state returns to INIT on the next edge.
  - An in-flight write may be lost; a pending response is dropped (rsp_valid=0).
  - The full zeroing sweep reruns.
- Back-to-back: if req_valid is held high across a returning-to-IDLE edge, the next command is accepted in the first IDLE cycle.

Test Plan:
- Reset, DEPTH=4 → ram_en=ram_we=1 with ram_addr=0,1,2,3 and wdata=0 on four consecutive cycles; init_done=1 and req_ready=1 on the fifth.
- Write addr 2 data 2'b10, then read addr 2, rsp_ready=1, RD_LAT=1 → ISSUE cycle shows en=1/we=1/addr=2/wdata=2; read rsp_valid rises 3 cycles after acceptance with rsp_rdata=2'b10.
- RD_LAT=3, read addr 1 holding 2'b01 → rsp_valid rises exactly 5 cycles after acceptance; rsp_rdata=2'b01.
- Read with rsp_ready=0 for 6 cycles → rsp_valid and rsp_rdata remain stable and req_ready=0; rsp_ready=1 → rsp_valid=0 and req_ready=1 on the next cycle.
- Reset asserted during RD_WAIT → next cycle rsp_valid=0, init_done=0, sweep restarts at addr 0; a subsequent read of any address returns 0.
- req_valid held high with alternating writes to addr 0..3 → accepted every 2 cycles, no command dropped or duplicated; read-back of each address matches its written data.
